// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   state_e    : arbiter FSM encoding
//   OWN_C/D    : owner encoding (core / debug port)
//   PRIO_*     : arbitration mode selectors
//   acc_ctl_t  : per-requester access controls latched at grant
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic OWN_C = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  typedef struct packed {
    logic        we;
    logic [31:0] wdata;
    logic [2:0]  funct3;
  } acc_ctl_t;

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way request picker.
//   req_c, req_d : pending requests
//   last_owner   : owner of the most recent grant (round-robin history)
//   prio_mode    : 0 = round-robin, 1 = C always wins a tie
//   grant_valid  : at least one request pending
//   grant_owner  : OWN_C / OWN_D
module arb_pick2
  import dmem_arb_pkg::*;
(
  input  logic req_c,
  input  logic req_d,
  input  logic last_owner,
  input  logic prio_mode,
  output logic grant_valid,
  output logic grant_owner
);

  always_comb begin
    grant_valid = req_c | req_d;
    grant_owner = OWN_C;
    if (req_c && req_d)
      grant_owner = prio_mode ? OWN_C : ((last_owner == OWN_C) ? OWN_D : OWN_C);
    else if (req_d)
      grant_owner = OWN_D;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core load/store path (C) and a
// debug/loader port (D). Each access is a req/ack transaction with a
// timeout; completion is signalled with a one-cycle done pulse.
//   clk, reset_n           : clock, async active-low reset
//   c_* / d_*              : requester ports (req, we, addr, wdata, funct3 in;
//                            done, rdata out)
//   core_stall             : c_req & ~c_done, combinational
//   m_*                    : memory port (req/we/addr/wdata/funct3 out,
//                            ack/rdata in)
//   bus_err                : transaction being completed timed out
//   busy                   : FSM not idle
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int TIMEOUT   = 255,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       c_wdata,
  input  logic [2:0]        c_funct3,
  output logic              c_done,
  output logic [31:0]       c_rdata,
  output logic              core_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [2:0]        d_funct3,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  output logic [2:0]        m_funct3,
  input  logic              m_ack,
  input  logic [31:0]       m_rdata,
  output logic              bus_err,
  output logic              busy
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state, state_nx;
  logic              owner, last_owner;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              grant_valid, grant_owner;
  logic              ack_ok, timeout;
  acc_ctl_t          c_ctl, d_ctl, g_ctl;

  arb_pick2 u_pick (
    .req_c       (c_req),
    .req_d       (d_req),
    .last_owner  (last_owner),
    .prio_mode   (PRIO_MODE == PRIO_FIXED),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  assign c_ctl = '{we: c_we, wdata: c_wdata, funct3: c_funct3};
  assign d_ctl = '{we: d_we, wdata: d_wdata, funct3: d_funct3};
  assign g_ctl = (grant_owner == OWN_D) ? d_ctl : c_ctl;

  // ack only counts while a request is actually on the bus
  assign ack_ok  = (state == ST_WAIT) && m_req && m_ack;
  // ack wins over an expiring counter in the same cycle
  assign timeout = (state == ST_WAIT) && !ack_ok && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (grant_valid) state_nx = ST_WAIT;
      ST_WAIT: if (ack_ok || timeout) state_nx = ST_RESP;
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner      <= OWN_C;
      last_owner <= OWN_D;   // C wins the first tie
      cnt        <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_funct3   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (grant_valid) begin
          owner      <= grant_owner;
          last_owner <= grant_owner;
          cnt        <= '0;
          err_q      <= 1'b0;
          m_req      <= 1'b1;
          m_we       <= g_ctl.we;
          m_addr     <= (grant_owner == OWN_D) ? d_addr : c_addr;
          m_wdata    <= g_ctl.wdata;
          m_funct3   <= g_ctl.funct3;
        end
        ST_WAIT: begin
          if (ack_ok) begin
            m_req   <= 1'b0;
            rdata_q <= m_we ? 32'd0 : m_rdata;
          end else if (timeout) begin
            m_req   <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b1;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign c_done     = (state == ST_RESP) && (owner == OWN_C);
  assign d_done     = (state == ST_RESP) && (owner == OWN_D);
  assign c_rdata    = c_done ? rdata_q : 32'd0;
  assign d_rdata    = d_done ? rdata_q : 32'd0;
  assign bus_err    = (state == ST_RESP) && err_q;
  assign busy       = (state != ST_IDLE);
  assign core_stall = c_req & ~c_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. dut0: round-robin, TIMEOUT=8, memory
// driven by the stimulus (or an immediate-ack model). dut1: fixed priority,
// immediate-ack memory model. dut0 completions are checked by a scoreboard.
module tb_dmem_arbiter;

  localparam logic [31:0] K = 32'hA5A5_0F0F;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [2:0]  c_funct3, d_funct3;

  logic        c_done0, d_done0, core_stall0, m_req0, m_we0, m_ack0, bus_err0, busy0;
  logic [31:0] c_rdata0, d_rdata0, m_addr0, m_wdata0, m_rdata0;
  logic [2:0]  m_funct3_0;
  logic        c_done1, d_done1, core_stall1, m_req1, m_we1, m_ack1, bus_err1, busy1;
  logic [31:0] c_rdata1, d_rdata1, m_addr1, m_wdata1, m_rdata1;
  logic [2:0]  m_funct3_1;

  logic        auto0, man_ack0, mon_en;
  logic [31:0] man_rdata0;

  assign m_ack0   = auto0 ? m_req0 : man_ack0;
  assign m_rdata0 = auto0 ? (m_addr0 ^ K) : man_rdata0;
  assign m_ack1   = m_req1;
  assign m_rdata1 = m_addr1 ^ K;

  dmem_arbiter #(.ADDR_W(32), .TIMEOUT(8), .PRIO_MODE(0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_funct3(c_funct3),
    .c_done(c_done0), .c_rdata(c_rdata0), .core_stall(core_stall0),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
    .d_done(d_done0), .d_rdata(d_rdata0),
    .m_req(m_req0), .m_we(m_we0), .m_addr(m_addr0), .m_wdata(m_wdata0), .m_funct3(m_funct3_0),
    .m_ack(m_ack0), .m_rdata(m_rdata0), .bus_err(bus_err0), .busy(busy0)
  );

  dmem_arbiter #(.ADDR_W(32), .TIMEOUT(8), .PRIO_MODE(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_funct3(c_funct3),
    .c_done(c_done1), .c_rdata(c_rdata1), .core_stall(core_stall1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
    .d_done(d_done1), .d_rdata(d_rdata1),
    .m_req(m_req1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1), .m_funct3(m_funct3_1),
    .m_ack(m_ack1), .m_rdata(m_rdata1), .bus_err(bus_err1), .busy(busy1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  typedef struct {
    logic        own;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  task automatic push(input logic own, input logic [31:0] rd, input logic err);
    exp_t e;
    e.own = own; e.rdata = rd; e.err = err;
    sb.push_back(e);
  endtask

  // scoreboard: every dut0 completion must match the oldest expectation
  always @(negedge clk) begin
    if (mon_en && (c_done0 || d_done0)) begin
      chk("sb_nonempty", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_owner", {d_done0, c_done0}, e.own ? 2'b10 : 2'b01);
        chk("sb_rdata", e.own ? d_rdata0 : c_rdata0, e.rdata);
        chk("sb_other_rdata", e.own ? c_rdata0 : d_rdata0, 0);
        chk("sb_bus_err", bus_err0, e.err);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_funct3 = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_funct3 = 0;
    auto0 = 0; man_ack0 = 0; man_rdata0 = 0; mon_en = 1;
    reset_n = 0;

    // reset state
    #12;
    chk("rst_m_req", m_req0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_c_done", c_done0, 0);
    chk("rst_d_done", d_done0, 0);
    chk("rst_bus_err", bus_err0, 0);
    chk("rst_stall", core_stall0, 0);
    chk("rst_m_addr", m_addr0, 0);
    chk("rst_m_req1", m_req1, 0);
    reset_n = 1;
    tick();

    // round-robin contention with immediate ack: C, D, C, D
    auto0 = 1;
    c_req = 1; d_req = 1; c_addr = 32'h200; d_addr = 32'h300;
    push(1'b0, 32'h200 ^ K, 0); push(1'b1, 32'h300 ^ K, 0);
    push(1'b0, 32'h200 ^ K, 0); push(1'b1, 32'h300 ^ K, 0);
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk("rr_c_done", c_done0, (k == 2 || k == 8));
      chk("rr_d_done", d_done0, (k == 5 || k == 11));
      if (k == 11) begin c_req = 0; d_req = 0; end
    end
    tick();
    chk("rr_idle", busy0, 0);
    auto0 = 0;

    // core load, ack two cycles after m_req
    c_req = 1; c_we = 0; c_addr = 32'h100;
    push(1'b0, 32'hDEADBEEF, 0);
    #1 chk("ld_stall_c0", core_stall0, 1);
    tick();
    chk("ld_m_req", m_req0, 1);
    chk("ld_m_addr", m_addr0, 32'h100);
    chk("ld_m_we", m_we0, 0);
    chk("ld_stall_c1", core_stall0, 1);
    tick();
    chk("ld_m_req_c2", m_req0, 1);
    tick();
    man_ack0 = 1; man_rdata0 = 32'hDEADBEEF;
    chk("ld_stall_c3", core_stall0, 1);
    tick();
    man_ack0 = 0;
    chk("ld_c_done", c_done0, 1);
    chk("ld_c_rdata", c_rdata0, 32'hDEADBEEF);
    chk("ld_stall_c4", core_stall0, 0);
    chk("ld_m_req_low", m_req0, 0);
    c_req = 0;
    tick();
    chk("ld_idle", busy0, 0);

    // core store, request dropped mid-WAIT
    c_req = 1; c_we = 1; c_wdata = 32'h12345678; c_funct3 = 3'b010; c_addr = 32'h44;
    push(1'b0, 32'h0, 0);
    tick();
    chk("st_m_we", m_we0, 1);
    chk("st_m_wdata", m_wdata0, 32'h12345678);
    chk("st_m_funct3", m_funct3_0, 3'b010);
    chk("st_m_addr", m_addr0, 32'h44);
    c_req = 0;
    tick();
    chk("st_m_req_held", m_req0, 1);
    chk("st_stall_dropped", core_stall0, 0);
    man_ack0 = 1; man_rdata0 = 32'hFFFFFFFF;
    tick();
    man_ack0 = 0;
    chk("st_c_done", c_done0, 1);
    chk("st_c_rdata", c_rdata0, 0);
    c_we = 0; c_funct3 = 0;
    tick();
    chk("st_idle", busy0, 0);

    // debug write that times out, then a clean debug read
    d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'hA0A0A0A0;
    push(1'b1, 32'h0, 1);
    tick();
    chk("to_m_req", m_req0, 1);
    chk("to_m_we", m_we0, 1);
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk("to_m_req_held", m_req0, 1);
    end
    tick();
    chk("to_m_req_drop", m_req0, 0);
    chk("to_d_done", d_done0, 1);
    chk("to_bus_err", bus_err0, 1);
    chk("to_d_rdata", d_rdata0, 0);
    d_we = 0; d_addr = 32'h84;
    push(1'b1, 32'h55AA55AA, 0);
    tick();
    chk("to2_idle", busy0, 0);
    tick();
    chk("to2_m_req", m_req0, 1);
    man_ack0 = 1; man_rdata0 = 32'h55AA55AA;
    tick();
    man_ack0 = 0; d_req = 0;
    chk("to2_d_done", d_done0, 1);
    chk("to2_bus_err", bus_err0, 0);
    chk("to2_d_rdata", d_rdata0, 32'h55AA55AA);
    tick();
    chk("to2_end_idle", busy0, 0);

    // reset mid-transaction
    c_req = 1; c_we = 0; c_addr = 32'h10;
    tick();
    chk("rm_m_req", m_req0, 1);
    tick();
    reset_n = 0;
    #1;
    chk("rm_async_m_req", m_req0, 0);
    chk("rm_async_busy", busy0, 0);
    chk("rm_async_c_done", c_done0, 0);
    chk("rm_async_m_addr", m_addr0, 0);
    chk("rm_stall_held", core_stall0, 1);
    #1 reset_n = 1;
    tick();
    chk("rm_reserve_m_req", m_req0, 1);
    chk("rm_reserve_addr", m_addr0, 32'h10);
    push(1'b0, 32'hCAFEF00D, 0);
    man_ack0 = 1; man_rdata0 = 32'hCAFEF00D;
    tick();
    man_ack0 = 0;
    chk("rm_c_done", c_done0, 1);
    c_req = 0;
    tick();
    chk("rm_idle", busy0, 0);
    man_ack0 = 1; man_rdata0 = 32'hBAD0BAD0;
    tick();
    chk("stray_busy", busy0, 0);
    chk("stray_m_req", m_req0, 0);
    chk("stray_c_done", c_done0, 0);
    man_ack0 = 0;
    tick();
    chk("stray_c_done2", c_done0, 0);
    chk("stray_d_done2", d_done0, 0);

    // fixed priority on dut1: only C served until c_req drops
    mon_en = 0; auto0 = 1;
    tick(); tick();
    chk("fx_idle", busy1, 0);
    c_req = 1; d_req = 1; c_addr = 32'h200; d_addr = 32'h300;
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk("fx_c_done", c_done1, (k == 2 || k == 5 || k == 8 || k == 11));
      chk("fx_d_done", d_done1, 0);
      if (k == 11) c_req = 0;
    end
    tick();
    chk("fx_d_done_c12", d_done1, 0);
    chk("fx_idle_c12", busy1, 0);
    tick();
    chk("fx_d_m_req", m_req1, 1);
    chk("fx_d_m_addr", m_addr1, 32'h300);
    chk("fx_d_done_c13", d_done1, 0);
    tick();
    chk("fx_d_done", d_done1, 1);
    chk("fx_d_rdata", d_rdata1, 32'h300 ^ K);
    chk("fx_c_done_c14", c_done1, 0);
    d_req = 0;
    tick(); tick();

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
